// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite register blocks: response codes and FSM states.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage

// File: rtl/axi_lite_strb_merge.sv
// Byte-strobe merge: each byte comes from wdata where its strobe is set, else from old_val.
module axi_lite_strb_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_val,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic [DATA_WIDTH-1:0]   merged
);

    for (genvar k = 0; k < DATA_WIDTH/8; k++) begin : g_byte
        assign merged[k*8 +: 8] = wstrb[k] ? wdata[k*8 +: 8] : old_val[k*8 +: 8];
    end

endmodule

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite slave register bank with per-register RO/RW mode and independent
// read/write channels. All channel outputs are registered.
module axi_lite_reg_bank
    import axi_lite_pkg::*;
#(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   ADDR_WIDTH = 4,
    parameter int                   NUM_REGS   = 4,
    parameter logic [NUM_REGS-1:0]  RO_MASK    = {{(NUM_REGS-1){1'b0}}, 1'b1}
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          s_awaddr,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    output logic [1:0]                     s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    input  logic [ADDR_WIDTH-1:0]          s_araddr,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    output logic [DATA_WIDTH-1:0]          s_rdata,
    output logic [1:0]                     s_rresp,
    output logic                           s_rvalid,
    input  logic                           s_rready,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] rw_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int STRB_W = DATA_WIDTH / 8;

    w_state_t w_state;
    r_state_t r_state;
    resp_t    bresp_q;
    resp_t    rresp_q;

    logic [DATA_WIDTH-1:0] regs   [NUM_REGS];
    logic [DATA_WIDTH-1:0] merged [NUM_REGS];

    // Write-side capture registers: AW and W may land in different cycles.
    logic              aw_done, w_done;
    logic [IDX_W-1:0]  awidx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic              aw_hs, w_hs, aw_have, w_have, commit;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic [NUM_REGS-1:0] wr_sel;
    logic              wr_ok;

    logic              ar_hs, rd_hit;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_WIDTH-1:0] rd_val;

    // Low address bits are ignored by the decode; ro_in slices of RW registers are never read.
    logic unused_bits;
    assign unused_bits = ^{s_awaddr[1:0], s_araddr[1:0], ro_in};

    assign aw_hs   = s_awvalid & s_awready;
    assign w_hs    = s_wvalid & s_wready;
    assign aw_have = aw_hs | aw_done;
    assign w_have  = w_hs | w_done;
    assign commit  = (w_state == W_IDLE) & aw_have & w_have;

    // A channel handshaking this cycle supplies its live values; otherwise use the captured ones.
    assign wr_idx  = aw_hs ? s_awaddr[ADDR_WIDTH-1:2] : awidx_q;
    assign wr_data = w_hs ? s_wdata : wdata_q;
    assign wr_strb = w_hs ? s_wstrb : wstrb_q;

    assign ar_hs   = s_arvalid & s_arready;
    assign rd_idx  = s_araddr[ADDR_WIDTH-1:2];

    // Write decode: one-hot select; only in-range RW targets succeed.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_REGS; i++)
            wr_sel[i] = (wr_idx == IDX_W'(i));
        wr_ok = |(wr_sel & ~RO_MASK);
    end

    // Read decode: RO registers come straight from ro_in, out-of-range reads return 0.
    always_comb begin
        rd_hit = 1'b0;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_hit = 1'b1;
                rd_val = RO_MASK[i] ? ro_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        axi_lite_strb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
            .old_val (regs[i]),
            .wdata   (wr_data),
            .wstrb   (wr_strb),
            .merged  (merged[i])
        );
        assign rw_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
    end

    // Register storage: updated on the commit edge for RW targets only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (wr_sel[i] && !RO_MASK[i]) regs[i] <= merged[i];
        end
    end

    // Write FSM: capture AW/W independently, commit once both held, then hold B until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state   <= W_IDLE;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b0;
            bresp_q   <= OKAY;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wr_pulse  <= '0;
        end else begin
            wr_pulse <= '0;
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_done <= 1'b1;
                        awidx_q <= s_awaddr[ADDR_WIDTH-1:2];
                    end
                    if (w_hs) begin
                        w_done  <= 1'b1;
                        wdata_q <= s_wdata;
                        wstrb_q <= s_wstrb;
                    end
                    if (commit) begin
                        w_state   <= W_RESP;
                        s_awready <= 1'b0;
                        s_wready  <= 1'b0;
                        s_bvalid  <= 1'b1;
                        bresp_q   <= wr_ok ? OKAY : SLVERR;
                        wr_pulse  <= wr_sel & ~RO_MASK;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                    end else begin
                        s_awready <= ~aw_have;
                        s_wready  <= ~w_have;
                    end
                end
                W_RESP: begin
                    if (s_bready) begin
                        w_state   <= W_IDLE;
                        s_bvalid  <= 1'b0;
                        s_awready <= 1'b1;
                        s_wready  <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM: latch data/response on AR acceptance, hold until R accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= R_IDLE;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            rresp_q   <= OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state   <= R_DATA;
                        s_arready <= 1'b0;
                        s_rvalid  <= 1'b1;
                        s_rdata   <= rd_val;
                        rresp_q   <= rd_hit ? OKAY : SLVERR;
                    end else begin
                        s_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_rready) begin
                        r_state   <= R_IDLE;
                        s_rvalid  <= 1'b0;
                        s_arready <= 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign s_bresp = bresp_q;
    assign s_rresp = rresp_q;

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Scoreboard bench for axi_lite_reg_bank (3 registers, reg0 read-only).
module tb_axi_lite_reg_bank;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] s_awaddr = '0;
    logic          s_awvalid = 1'b0;
    logic          s_awready;
    logic [DW-1:0] s_wdata = '0;
    logic [3:0]    s_wstrb = '0;
    logic          s_wvalid = 1'b0;
    logic          s_wready;
    logic [1:0]    s_bresp;
    logic          s_bvalid;
    logic          s_bready = 1'b1;
    logic [AW-1:0] s_araddr = '0;
    logic          s_arvalid = 1'b0;
    logic          s_arready;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rvalid;
    logic          s_rready = 1'b1;
    logic [NR*DW-1:0] ro_in = '0;
    logic [NR*DW-1:0] rw_out;
    logic [NR-1:0]    wr_pulse;

    int checks = 0;
    int failures = 0;

    logic [1:0]  bq [$];
    logic [33:0] rq [$];   // {rdata, rresp}

    axi_lite_reg_bank #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RO_MASK(3'b001)
    ) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .ro_in(ro_in), .rw_out(rw_out), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // B-channel monitor: one pop per accepted response.
    always @(negedge clk) begin
        if (!rst && s_bvalid && s_bready) begin
            if (bq.size() == 0) chk("unexpected_bresp", 128'(s_bresp), 128'hx_dead);
            else chk("bresp", 128'(s_bresp), 128'(bq.pop_front()));
        end
    end

    // R-channel monitor.
    always @(negedge clk) begin
        if (!rst && s_rvalid && s_rready) begin
            if (rq.size() == 0) chk("unexpected_rdata", 128'({s_rdata, s_rresp}), 128'hx_dead);
            else chk("rdata_rresp", 128'({s_rdata, s_rresp}), 128'(rq.pop_front()));
        end
    end

    function automatic logic [DW-1:0] slice(input int i);
        return rw_out[i*DW +: DW];
    endfunction

    // Issue AW after aw_dly cycles and W after w_dly cycles; returns just after the commit edge.
    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] st,
                         input logic [1:0] exp, input bit push, input int aw_dly, input int w_dly);
        bit aw_pend = 1, w_pend = 1, a_acc, w_acc;
        int c = 0;
        if (push) bq.push_back(exp);
        s_awaddr = a; s_wdata = d; s_wstrb = st;
        while ((aw_pend || w_pend) && c < 50) begin
            if (aw_pend && c >= aw_dly) s_awvalid = 1'b1;
            if (w_pend && c >= w_dly) s_wvalid = 1'b1;
            @(negedge clk);
            a_acc = s_awvalid && s_awready;
            w_acc = s_wvalid && s_wready;
            @(posedge clk); #1;
            if (a_acc) begin s_awvalid = 1'b0; aw_pend = 0; end
            if (w_acc) begin s_wvalid = 1'b0; w_pend = 0; end
            c++;
        end
        if (aw_pend || w_pend) begin
            chk("write_accept_timeout", 128'({aw_pend, w_pend}), 128'd0);
            s_awvalid = 1'b0; s_wvalid = 1'b0;
        end
    endtask

    task automatic read(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] rsp);
        int c = 0;
        bit acc = 0;
        rq.push_back({d, rsp});
        s_araddr = a; s_arvalid = 1'b1;
        while (!acc && c < 50) begin
            @(negedge clk);
            acc = s_arready;
            @(posedge clk); #1;
            c++;
        end
        s_arvalid = 1'b0;
        if (!acc) chk("read_accept_timeout", 128'd1, 128'd0);
    endtask

    task automatic drain(input string name);
        int c = 0;
        while ((bq.size() != 0 || rq.size() != 0) && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        chk(name, 128'(bq.size() + rq.size()), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ro_in[0 +: DW] = 32'hA5A5A5A5;
        ro_in[DW +: DW] = 32'h5555AAAA;   // ignored: reg1 is RW
        #12;
        chk("reset_outputs", 128'({s_awready, s_wready, s_bvalid, s_arready, s_rvalid, wr_pulse, s_bresp, s_rresp}), 128'd0);
        chk("reset_rw_out", 128'(rw_out), 128'd0);
        chk("reset_rdata", 128'(s_rdata), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("readies_after_reset", 128'({s_awready, s_wready, s_arready}), 128'b111);

        // AW+W same cycle to reg1.
        write(4'h4, 32'hDEADBEEF, 4'hF, 2'b00, 1, 0, 0);
        chk("bvalid_after_commit", 128'(s_bvalid), 128'd1);
        chk("wr_pulse_reg1", 128'(wr_pulse), 128'b010);
        chk("reg1_value", 128'(slice(1)), 128'hDEADBEEF);
        @(posedge clk); #1;
        chk("wr_pulse_one_cycle", 128'(wr_pulse), 128'd0);
        drain("drain_t1");

        // W two cycles ahead of AW, partial strobes over reg2=FFFFFFFF.
        write(4'h8, 32'hFFFFFFFF, 4'hF, 2'b00, 1, 0, 0);
        drain("drain_t2a");
        write(4'h8, 32'h12345678, 4'b0101, 2'b00, 1, 2, 0);
        chk("reg2_strb_merge", 128'(slice(2)), 128'hFF34FF78);
        drain("drain_t2b");

        // Write to RO reg0: SLVERR, no pulse; read returns ro_in.
        write(4'h0, 32'h11111111, 4'hF, 2'b10, 1, 0, 0);
        chk("ro_write_no_pulse", 128'(wr_pulse), 128'd0);
        chk("ro_slice_zero", 128'(slice(0)), 128'd0);
        drain("drain_t3a");
        read(4'h0, 32'hA5A5A5A5, 2'b00);
        read(4'h5, 32'hDEADBEEF, 2'b00);   // low address bits ignored
        drain("drain_t3b");

        // Out of range.
        read(4'hC, 32'h0, 2'b10);
        write(4'hC, 32'hCAFEF00D, 4'hF, 2'b10, 1, 0, 0);
        chk("oor_no_pulse", 128'(wr_pulse), 128'd0);
        drain("drain_t4");

        // All-zero strobe: unchanged, OKAY, pulse still fires.
        write(4'h4, 32'hFFFFFFFF, 4'h0, 2'b00, 1, 1, 0);
        chk("zero_strb_pulse", 128'(wr_pulse), 128'b010);
        chk("zero_strb_unchanged", 128'(slice(1)), 128'hDEADBEEF);
        drain("drain_t5");

        // Same-edge read and write to reg2: read sees pre-write value.
        rq.push_back({32'hFF34FF78, 2'b00});
        bq.push_back(2'b00);
        s_araddr = 4'h8; s_arvalid = 1'b1;
        s_awaddr = 4'h8; s_awvalid = 1'b1; s_wdata = 32'h0000BEEF; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(posedge clk); #1;
        s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
        chk("same_edge_new_value", 128'(slice(2)), 128'h0000BEEF);
        drain("drain_t6");

        // Stall on bready=0; concurrent read still completes.
        s_bready = 1'b0;
        write(4'h4, 32'h0BADF00D, 4'hF, 2'b00, 1, 0, 0);
        read(4'h4, 32'h0BADF00D, 2'b00);
        drain_r: begin
            int c = 0;
            while (rq.size() != 0 && c < 50) begin @(posedge clk); #1; c++; end
            chk("stall_read_done", 128'(rq.size()), 128'd0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", 128'({s_bvalid, s_awready, s_wready, s_bresp}), 128'b10000);
        end
        @(posedge clk); #1;
        s_bready = 1'b1;
        drain("drain_t7");

        // Reset during W_RESP discards the response.
        s_bready = 1'b0;
        write(4'h8, 32'h77777777, 4'hF, 2'b00, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_in_resp_outputs", 128'({s_bvalid, s_awready, s_wready}), 128'd0);
        chk("rst_in_resp_regs", 128'(rw_out), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        s_bready = 1'b1;
        @(posedge clk); #1;
        write(4'h4, 32'h11223344, 4'hF, 2'b00, 1, 0, 0);
        chk("post_reset_write", 128'(slice(1)), 128'h11223344);
        read(4'h8, 32'h0, 2'b00);
        drain("drain_t8");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
